// File: rtl/i2c_seg_mux.sv
// I2C target holding one segment byte per digit plus a control byte, driving a
// time-multiplexed, PWM-dimmed common-select 7-segment display.
//
// state     | meaning
// IDLE      | bus free, or transfer not addressed to us
// ADDR      | shifting in 7-bit address + R/W
// ADDR_ACK  | driving ACK for our address
// PTR       | shifting in register pointer
// PTR_ACK   | driving ACK for pointer byte
// WDATA     | shifting in write data
// WDATA_ACK | driving ACK, byte already written to reg[ptr]
// RDATA     | shifting out reg[ptr], only 0 bits are driven
// RDATA_ACK | SDA released, sampling controller ACK/NACK
module i2c_seg_mux #(
    parameter logic [6:0] I2C_ADDR       = 7'h42,
    parameter int         NUM_DIGITS     = 4,
    parameter int         REFRESH_W      = 12,
    parameter bit         SEG_ACTIVE_LOW = 1'b0,
    parameter bit         SEL_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i2c_scl_i,
    input  logic                  i2c_sda_i,
    output logic                  i2c_sda_o,
    output logic                  i2c_sda_oe,
    output logic [6:0]            seg_o,
    output logic [NUM_DIGITS-1:0] sel_o
);
    localparam int PW = $clog2(NUM_DIGITS + 1);
    localparam int IW = $clog2(NUM_DIGITS);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            oe_d;
    logic [PW-1:0]   ptr_q, ptr_d, ptr_inc;
    logic            rw_q, rw_d;
    logic            wr_en;
    logic [7:0]      dig_q [NUM_DIGITS];
    logic [7:0]      ctrl_q;
    logic [7:0]      rd_data;

    // Sync flops reset to the idle-bus level so release of reset never fakes an edge.
    logic [1:0] scl_sync, sda_sync;
    logic       scl_p, sda_p, scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_p    <= 1'b1;
            sda_p    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], i2c_scl_i};
            sda_sync <= {sda_sync[0], i2c_sda_i};
            scl_p    <= scl_sync[1];
            sda_p    <= sda_sync[1];
        end
    end

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_p;
    assign scl_fall  = ~scl_s & scl_p;
    assign start_det = scl_s & scl_p & sda_p & ~sda_s;
    assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;

    assign i2c_sda_o = 1'b0;
    assign ptr_inc   = (ptr_q == PW'(NUM_DIGITS)) ? '0 : ptr_q + PW'(1);

    always_comb begin
        rd_data = 8'h00;
        if (ptr_q == PW'(NUM_DIGITS))
            rd_data = ctrl_q;
        else if (int'(ptr_q) < NUM_DIGITS)
            rd_data = dig_q[ptr_q[IW-1:0]];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        oe_d    = i2c_sda_oe;
        ptr_d   = ptr_q;
        rw_d    = rw_q;
        wr_en   = 1'b0;
        if (stop_det) begin
            state_d = IDLE;
            oe_d    = 1'b0;
        end else if (start_det) begin
            state_d = ADDR;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        cnt_d = 4'd0;
                        if (shift_q[7:1] == I2C_ADDR) begin
                            rw_d    = shift_q[0];
                            oe_d    = 1'b1;
                            state_d = ADDR_ACK;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_d = 4'd0;
                        if (rw_q) begin
                            shift_d = rd_data;
                            oe_d    = ~rd_data[7];
                            state_d = RDATA;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = PTR;
                        end
                    end
                end
                PTR: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        cnt_d   = 4'd0;
                        ptr_d   = PW'(shift_q % 8'(NUM_DIGITS + 1));
                        oe_d    = 1'b1;
                        state_d = PTR_ACK;
                    end
                end
                WDATA: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        cnt_d   = 4'd0;
                        wr_en   = 1'b1;
                        ptr_d   = ptr_inc;
                        oe_d    = 1'b1;
                        state_d = WDATA_ACK;
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        oe_d    = 1'b0;
                        state_d = WDATA;
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            state_d = RDATA_ACK;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            oe_d    = ~shift_q[6];
                        end
                    end
                end
                RDATA_ACK: begin
                    // ACK bumps the pointer on the rise; next byte loads on the fall.
                    if (scl_rise) begin
                        if (!sda_s) ptr_d = ptr_inc;
                        else        state_d = IDLE;
                    end else if (scl_fall) begin
                        cnt_d   = 4'd0;
                        shift_d = rd_data;
                        oe_d    = ~rd_data[7];
                        state_d = RDATA;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 8'h00;
            i2c_sda_oe <= 1'b0;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            i2c_sda_oe <= oe_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) dig_q[i] <= 8'h00;
            ctrl_q <= 8'hF1;
        end else if (wr_en) begin
            if (ptr_q == PW'(NUM_DIGITS))
                ctrl_q <= shift_q;
            else if (int'(ptr_q) < NUM_DIGITS)
                dig_q[ptr_q[IW-1:0]] <= shift_q;
        end
    end

    logic [REFRESH_W-1:0]  slot_q;
    logic [IW-1:0]         idx_q, idx_nxt;
    logic [6:0]            seg_lat_q;
    logic                  active;
    logic [NUM_DIGITS-1:0] sel_hot;

    assign idx_nxt = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    assign sel_hot = NUM_DIGITS'(1) << idx_q;
    assign active  = ctrl_q[0] && (slot_q >= REFRESH_W'(4))
                     && (slot_q[REFRESH_W-1 -: 4] <= ctrl_q[7:4]);

    // Segment byte is captured once per slot so a write never tears a lit digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q    <= '0;
            idx_q     <= '0;
            seg_lat_q <= 7'h00;
        end else begin
            slot_q <= slot_q + REFRESH_W'(1);
            if (&slot_q) begin
                idx_q     <= idx_nxt;
                seg_lat_q <= dig_q[idx_nxt][6:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_o <= {7{SEG_ACTIVE_LOW}};
            sel_o <= {NUM_DIGITS{SEL_ACTIVE_LOW}};
        end else begin
            seg_o <= (active ? seg_lat_q : 7'h00) ^ {7{SEG_ACTIVE_LOW}};
            sel_o <= (active ? sel_hot : '0) ^ {NUM_DIGITS{SEL_ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_i2c_seg_mux.sv
// Directed bench for i2c_seg_mux: bit-banged I2C controller, register read-back
// and display observation on an active-high and an active-low-segment instance.
module tb_i2c_seg_mux;
    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          scl_m, sda_m;
    logic          sda_o_a, sda_oe_a, sda_o_b, sda_oe_b;
    logic [6:0]    seg_a, seg_b;
    logic [ND-1:0] sel_a, sel_b;
    logic          sda_bus;

    int total = 0;
    int bad   = 0;
    int oe_cycles = 0;

    logic [7:0] wbuf [8];
    logic [7:0] rbuf [8];

    assign sda_bus = sda_m & ~sda_oe_a & ~sda_oe_b;

    always #5 clk = ~clk;
    always @(posedge clk) if (sda_oe_a || sda_oe_b) oe_cycles++;

    i2c_seg_mux #(.I2C_ADDR(7'h42), .NUM_DIGITS(ND), .REFRESH_W(6),
                  .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .i2c_scl_i(scl_m), .i2c_sda_i(sda_bus),
        .i2c_sda_o(sda_o_a), .i2c_sda_oe(sda_oe_a), .seg_o(seg_a), .sel_o(sel_a));

    i2c_seg_mux #(.I2C_ADDR(7'h42), .NUM_DIGITS(ND), .REFRESH_W(6),
                  .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .i2c_scl_i(scl_m), .i2c_sda_i(sda_bus),
        .i2c_sda_o(sda_o_b), .i2c_sda_oe(sda_oe_b), .seg_o(seg_b), .sel_o(sel_b));

    task automatic hp;
        repeat (8) @(posedge clk);
    endtask

    task automatic bus_start;
        sda_m = 1'b1; hp; scl_m = 1'b1; hp; sda_m = 1'b0; hp; scl_m = 1'b0; hp;
    endtask

    task automatic bus_stop;
        sda_m = 1'b0; hp; scl_m = 1'b1; hp; sda_m = 1'b1; hp;
    endtask

    task automatic put_bit(input logic b);
        sda_m = b; hp; scl_m = 1'b1; hp; scl_m = 1'b0; hp;
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; hp; scl_m = 1'b1; hp; b = sda_bus; scl_m = 1'b0; hp;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(b);
        ack = ~b;
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(~ack);
    endtask

    task automatic wr_regs(input logic [7:0] ptr, input int n, output int nacks);
        logic a;
        nacks = 0;
        bus_start;
        send_byte(8'h84, a); if (!a) nacks++;
        send_byte(ptr, a);   if (!a) nacks++;
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i], a);
            if (!a) nacks++;
        end
        bus_stop;
    endtask

    task automatic rd_regs(input logic [7:0] ptr, input int n, output int nacks);
        logic a;
        logic [7:0] d;
        nacks = 0;
        bus_start;
        send_byte(8'h84, a); if (!a) nacks++;
        send_byte(ptr, a);   if (!a) nacks++;
        bus_start;
        send_byte(8'h85, a); if (!a) nacks++;
        for (int i = 0; i < n; i++) begin
            recv_byte(d, i != n - 1);
            rbuf[i] = d;
        end
        bus_stop;
    endtask

    task automatic find_digit(input logic [ND-1:0] sel_exp, output logic found,
                              output logic [6:0] sa, output logic [6:0] sb);
        found = 1'b0; sa = '0; sb = '0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (sel_a == sel_exp) begin
                found = 1'b1; sa = seg_a; sb = seg_b;
            end
        end
    endtask

    task automatic count_active(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (sel_a != '0 || seg_a != '0) n++;
        end
    endtask

    task automatic test_reset;
        int nk;
        logic [7:0] exp_v [5];
        exp_v = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hF1};
        rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (sda_oe_a !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b exp=0", sda_oe_a); end
        total++; if (sda_o_a !== 1'b0) begin bad++; $display("FAIL reset_sda_o got=%b exp=0", sda_o_a); end
        total++; if (seg_a !== 7'h00 || sel_a !== 4'b0000) begin bad++; $display("FAIL reset_disp got=%h/%b exp=00/0000", seg_a, sel_a); end
        total++; if (seg_b !== 7'h7F) begin bad++; $display("FAIL reset_seg_low got=%h exp=7f", seg_b); end
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(posedge clk);
        rd_regs(8'h00, 5, nk);
        total++; if (nk !== 0) begin bad++; $display("FAIL reset_rd_ack got=%0d exp=0 nacks", nk); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rbuf[i] !== exp_v[i]) begin bad++; $display("FAIL reset_rd[%0d] got=%h exp=%h", i, rbuf[i], exp_v[i]); end
        end
    endtask

    task automatic test_write_display;
        int nk, n;
        logic f;
        logic [6:0] sa, sb;
        wbuf[0] = 8'h3F; wbuf[1] = 8'h06; wbuf[2] = 8'h5B; wbuf[3] = 8'h4F;
        wr_regs(8'h00, 4, nk);
        total++; if (nk !== 0) begin bad++; $display("FAIL wr_ack got=%0d exp=0 nacks", nk); end
        repeat (300) @(posedge clk);
        find_digit(4'b0001, f, sa, sb);
        total++; if (f !== 1'b1 || sa !== 7'h3F) begin bad++; $display("FAIL disp_d0 got found=%b seg=%h exp found=1 seg=3f", f, sa); end
        find_digit(4'b1000, f, sa, sb);
        total++; if (f !== 1'b1 || sa !== 7'h4F) begin bad++; $display("FAIL disp_d3 got found=%b seg=%h exp found=1 seg=4f", f, sa); end
        count_active(256, n);
        total++; if (n !== 240) begin bad++; $display("FAIL duty_b15 got=%0d exp=240", n); end
    endtask

    task automatic test_read_back;
        int nk;
        logic [7:0] exp_v [3];
        exp_v = '{8'h06, 8'h5B, 8'h4F};
        rd_regs(8'h01, 3, nk);
        total++; if (nk !== 0) begin bad++; $display("FAIL rb_ack got=%0d exp=0 nacks", nk); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rbuf[i] !== exp_v[i]) begin bad++; $display("FAIL rb[%0d] got=%h exp=%h", i, rbuf[i], exp_v[i]); end
        end
        @(negedge clk);
        total++; if (sda_oe_a !== 1'b0) begin bad++; $display("FAIL rb_release got=%b exp=0", sda_oe_a); end
    endtask

    task automatic test_wrap;
        int nk, n;
        logic [7:0] exp_v [5];
        exp_v = '{8'h33, 8'h06, 8'h5B, 8'h11, 8'h22};
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        wr_regs(8'h03, 3, nk);
        total++; if (nk !== 0) begin bad++; $display("FAIL wrap_ack got=%0d exp=0 nacks", nk); end
        rd_regs(8'h00, 5, nk);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rbuf[i] !== exp_v[i]) begin bad++; $display("FAIL wrap_rd[%0d] got=%h exp=%h", i, rbuf[i], exp_v[i]); end
        end
        count_active(300, n);
        total++; if (n !== 0) begin bad++; $display("FAIL disabled_dark got=%0d exp=0 lit cycles", n); end
    endtask

    task automatic test_foreign;
        int nk, oe0;
        logic a;
        oe0 = oe_cycles;
        bus_start;
        send_byte(8'h86, a);
        total++; if (a !== 1'b0) begin bad++; $display("FAIL foreign_ack got=%b exp=0", a); end
        send_byte(8'h00, a);
        send_byte(8'h77, a);
        bus_stop;
        total++; if (oe_cycles !== oe0) begin bad++; $display("FAIL foreign_oe got=%0d exp=0 driven cycles", oe_cycles - oe0); end
        rd_regs(8'h00, 1, nk);
        total++; if (nk !== 0 || rbuf[0] !== 8'h33) begin bad++; $display("FAIL foreign_after got nacks=%0d reg0=%h exp 0/33", nk, rbuf[0]); end
    endtask

    task automatic test_brightness;
        int nk, n;
        logic f;
        logic [6:0] sa, sb;
        wbuf[0] = 8'h01;
        wr_regs(8'h04, 1, nk);
        repeat (10) @(posedge clk);
        count_active(256, n);
        total++; if (n !== 0) begin bad++; $display("FAIL bright0 got=%0d exp=0", n); end
        wbuf[0] = 8'h11;
        wr_regs(8'h04, 1, nk);
        repeat (10) @(posedge clk);
        count_active(256, n);
        total++; if (n !== 16) begin bad++; $display("FAIL bright1 got=%0d exp=16", n); end
        find_digit(4'b0000, f, sa, sb);
        total++; if (f !== 1'b1 || sb !== 7'h7F) begin bad++; $display("FAIL seg_low_idle got=%h exp=7f", sb); end
        wbuf[0] = 8'hF1;
        wr_regs(8'h04, 1, nk);
        repeat (300) @(posedge clk);
        find_digit(4'b0001, f, sa, sb);
        total++; if (f !== 1'b1 || sb !== 7'h4C || sa !== 7'h33) begin bad++; $display("FAIL seg_low_d0 got=%h/%h exp=4c/33", sb, sa); end
    endtask

    task automatic test_ptr_mod;
        int nk;
        wbuf[0] = 8'hA5;
        wr_regs(8'h07, 1, nk);
        rd_regs(8'h02, 1, nk);
        total++; if (rbuf[0] !== 8'hA5) begin bad++; $display("FAIL ptr_mod7 got=%h exp=a5", rbuf[0]); end
        wbuf[0] = 8'h3F;
        wr_regs(8'hFF, 1, nk);
        rd_regs(8'h00, 1, nk);
        total++; if (rbuf[0] !== 8'h3F) begin bad++; $display("FAIL ptr_modff got=%h exp=3f", rbuf[0]); end
    endtask

    task automatic test_reset_mid_read;
        int nk;
        logic a;
        bus_start;
        send_byte(8'h84, a);
        send_byte(8'h01, a);
        bus_start;
        send_byte(8'h85, a);
        total++; if (sda_oe_a !== 1'b1) begin bad++; $display("FAIL midrd_drive got=%b exp=1", sda_oe_a); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (sda_oe_a !== 1'b0) begin bad++; $display("FAIL midrd_async got=%b exp=0", sda_oe_a); end
        sda_m = 1'b1; scl_m = 1'b1;
        repeat (4) @(posedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        rd_regs(8'h04, 1, nk);
        total++; if (nk !== 0 || rbuf[0] !== 8'hF1) begin bad++; $display("FAIL midrd_ctrl got=%h exp=f1", rbuf[0]); end
        rd_regs(8'h00, 4, nk);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rbuf[i] !== 8'h00) begin bad++; $display("FAIL midrd_dig[%0d] got=%h exp=00", i, rbuf[i]); end
        end
    endtask

    initial begin
        test_reset;
        test_write_display;
        test_read_back;
        test_wrap;
        test_foreign;
        test_brightness;
        test_ptr_mod;
        test_reset_mid_read;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
